vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-clock arbiter sharing the one-port 32K×8 VRAM (`spram32k8`) between two requesters: the scan-out pixel fetcher (reads, deadline-critical) and the CPU register interface (writes via the auto-incrementing write address). It sits between the VDP host-register decoder and the RAM macro. CPU writes are buffered in a small FIFO so a write strobe never stalls the host bus. Display reads win every cycle, subject to an optional starvation guard.

## Interface
- `ADDR_W`, 15, VRAM address width
- `DATA_W`, 8, VRAM data width
- `FIFO_DEPTH`, 4, CPU write FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 8, consecutive display grants before a forced CPU slot (guard only)

- `clk`  in  1  system clock; single clock for the whole block
- `reset`  in  1  synchronous, active-high reset
- `disp_req`  in  1  display read request; held until acknowledged
- `disp_addr`  in  ADDR_W  display read address
- `disp_ack`  out  1  request granted this cycle (combinational)
- `disp_valid`  out  1  `disp_data` valid strobe
- `disp_data`  out  DATA_W  read data
- `cpu_wr_valid`  in  1  one-cycle write push
- `cpu_wr_addr`  in  ADDR_W  write address
- `cpu_wr_data`  in  DATA_W  write data
- `cpu_wr_ready`  out  1  FIFO not full
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `ram_addr`  out  ADDR_W  to RAM (combinational from grant)
- `ram_we`  out  1  RAM write enable
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rdata`  in  DATA_W  RAM read data, valid one cycle after address

## Operation
- Each cycle, the grant is decided among `disp_req` and FIFO non-empty. Priority: display, then CPU. With the guard enabled, a forced CPU slot overrides the display.
- Display grant: `ram_addr=disp_addr`, `ram_we=0`, `disp_ack=1`.
- CPU grant: pop the FIFO head and drive `ram_addr/ram_wdata` from it with `ram_we=1`.
- Idle: `ram_we=0` and `ram_addr` holds its last value.
- FIFO push occurs when `cpu_wr_valid && cpu_wr_ready`.
  - A push while full is dropped and is not an error. The upstream decoder must honour `cpu_wr_ready`.
  - A simultaneous push and pop leaves `fifo_level` unchanged.
  - A push into an empty FIFO is not eligible for grant until the next cycle: there is no bypass.
- `cpu_wr_ready = (fifo_level != FIFO_DEPTH)`. It is registered-state-derived and combinational from `fifo_level` only.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth. `fifo_level` saturates at neither end, because the rules above make overflow and underflow impossible.
- Reset:
  - Pointers, `fifo_level`, `disp_valid`, starve counter and pipeline flag all go to 0. `disp_data` goes to 0.
  - Queued writes are discarded.
  - A read in flight at reset never produces `disp_valid`.

## Timing
- Display read latency: request granted in cycle n → RAM samples at the end of n → `ram_rdata` valid in n+1 → `disp_data` registered at the end of n+1 → `disp_valid=1` in cycle n+2 for exactly one cycle per grant.
- Back-to-back display grants give one `disp_valid` per cycle (fully pipelined).
- A CPU write is committed at the RAM edge ending its grant cycle.
- Minimum push-to-commit latency is 1 cycle (push at n, grant at n+1).
- A display read of an address whose write is still queued returns old data. No forwarding is provided.
- `disp_ack` low means the requester holds `disp_req` and `disp_addr` unchanged.

## Configuration
- `VRAM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each display grant while the FIFO is non-empty.
  - The counter clears on any CPU grant or when the FIFO is empty.
  - When it reaches `STARVE_LIMIT`, the next cycle grants CPU even if `disp_req=1`, with `disp_ack=0`, and the counter clears.
- Undefined: strict display priority. The CPU may starve indefinitely, which is acceptable when the fetcher leaves blanking gaps. The counter logic is absent.

## Structure
- Shared package `vdp_pkg`: `vram_addr_t`/`vram_data_t` typedefs (15/8 bits), a grant enum `{GNT_NONE, GNT_DISP, GNT_CPU}`, and default `VRAM_FIFO_DEPTH`.
- One natural sub-module: `vram_wr_fifo`, a synchronous FIFO with push/pop/level that stores `{addr,data}`. The arbiter keeps the grant logic, read pipeline flag and starve counter.

## Test plan
- Reset then idle: `cpu_wr_ready=1`, `fifo_level=0`, `disp_valid=0`, `ram_we=0` for 10 cycles.
- CPU pushes 0x0010←0xA5 with no display traffic → next cycle `ram_we=1`, `ram_addr=0x0010`, `ram_wdata=0xA5`. A later display read of 0x0010 gives `disp_data=0xA5` two cycles after ack.
- Five pushes while `disp_req` is held high (guard off) → `cpu_wr_ready=0` after the 4th, the 5th is dropped, no `ram_we` occurs. After dropping `disp_req`, exactly 4 writes commit in order.
- Guard on, `STARVE_LIMIT=8`, continuous `disp_req` with 1 queued write → the 9th cycle has `disp_ack=0`, `ram_we=1`, and display grants resume afterwards.
- Push on the same cycle as a pop at `fifo_level=2` → level stays 2 and data order is preserved.
- `reset` asserted the cycle after a display grant and with 3 writes queued → no `disp_valid`, `fifo_level=0`, and none of the queued writes reach the RAM.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared VDP types: VRAM address/data words, arbiter grant encoding and default sizing.
package vdp_pkg;

    localparam int VRAM_ADDR_W       = 15;
    localparam int VRAM_DATA_W       = 8;
    localparam int VRAM_FIFO_DEPTH   = 4;
    localparam int VRAM_STARVE_LIMIT = 8;

    typedef logic [VRAM_ADDR_W-1:0] vram_addr_t;
    typedef logic [VRAM_DATA_W-1:0] vram_data_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_CPU
    } grant_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the RAM macro.
interface vram_arbiter_if
    import vdp_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int FIFO_DEPTH = VRAM_FIFO_DEPTH
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_ack;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_data;

    logic              cpu_wr_valid;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_wr_ready;
    logic [LVL_W-1:0]  fifo_level;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side.
    modport slave (
        input  disp_req, disp_addr, cpu_wr_valid, cpu_wr_addr, cpu_wr_data, ram_rdata,
        output disp_ack, disp_valid, disp_data, cpu_wr_ready, fifo_level,
        output ram_addr, ram_we, ram_wdata
    );

    // Requesters plus RAM side.
    modport master (
        output disp_req, disp_addr, cpu_wr_valid, cpu_wr_addr, cpu_wr_data, ram_rdata,
        input  disp_ack, disp_valid, disp_data, cpu_wr_ready, fifo_level,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO holding queued CPU writes as {addr,data}; pushes while full are dropped.
module vram_wr_fifo
    import vdp_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int DEPTH  = VRAM_FIFO_DEPTH,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [LVL_W-1:0]  level,
    output logic              ready,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic                     wr_en;
    logic                     rd_en;

    assign ready = (level != LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign wr_en = push && ready;
    assign rd_en = pop && !empty;

    assign {head_addr, head_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: display reads take priority, CPU writes drain from a FIFO in free cycles.
// Optional starvation guard enabled by defining VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter
    import vdp_pkg::*;
#(
    parameter int ADDR_W       = $bits(vram_addr_t),
    parameter int DATA_W       = $bits(vram_data_t),
    parameter int FIFO_DEPTH   = VRAM_FIFO_DEPTH,
    parameter int STARVE_LIMIT = VRAM_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    grant_t            gnt;
    logic              pop;
    logic              fifo_empty;
    logic              force_cpu;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [ADDR_W-1:0] addr_hold;
    logic              vld_p1;

    vram_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.cpu_wr_valid),
        .pop       (pop),
        .push_addr (bus.cpu_wr_addr),
        .push_data (bus.cpu_wr_data),
        .head_addr (head_addr),
        .head_data (head_data),
        .level     (bus.fifo_level),
        .ready     (bus.cpu_wr_ready),
        .empty     (fifo_empty)
    );

    // No grants while in reset so queued writes cannot leak into the RAM.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (force_cpu)           gnt = GNT_CPU;
            else if (bus.disp_req)   gnt = GNT_DISP;
            else if (!fifo_empty)    gnt = GNT_CPU;
        end
    end

    assign pop           = (gnt == GNT_CPU);
    assign bus.disp_ack  = (gnt == GNT_DISP);
    assign bus.ram_we    = pop;
    assign bus.ram_wdata = head_data;

    always_comb begin
        bus.ram_addr = addr_hold;
        case (gnt)
            GNT_DISP: bus.ram_addr = bus.disp_addr;
            GNT_CPU:  bus.ram_addr = head_addr;
            default:  bus.ram_addr = addr_hold;
        endcase
    end

    always_ff @(posedge clk) begin
        addr_hold <= bus.ram_addr;
    end

    // Stage p1: RAM is presenting read data for the grant of the previous cycle.
    // Stage p2: data captured into disp_data, strobe on disp_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1         <= 1'b0;
            bus.disp_valid <= 1'b0;
            bus.disp_data  <= '0;
        end else begin
            vld_p1         <= bus.disp_ack;
            bus.disp_valid <= vld_p1;
            if (vld_p1) begin
                bus.disp_data <= bus.ram_rdata;
            end
        end
    end

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign force_cpu = (starve_cnt == CNT_W'(STARVE_LIMIT)) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (gnt == GNT_CPU || fifo_empty) begin
            starve_cnt <= '0;
        end else if (gnt == GNT_DISP) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign force_cpu = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table plus multi-cycle sequences, behavioural RAM model.
module tb_vram_arbiter;
    import vdp_pkg::*;

    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int NVEC         = 22;

    typedef struct {
        int dreq; int daddr; int push; int waddr; int wdata;
        int ack;  int we;    int ca;   int raddr; int wd;
        int rdy;  int lvl;   int dv;   int dd;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus();

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic drive(int dreq, int daddr, int push, int waddr, int wdata);
        bus.disp_req     = 1'(dreq);
        bus.disp_addr    = 15'(daddr);
        bus.cpu_wr_valid = 1'(push);
        bus.cpu_wr_addr  = 15'(waddr);
        bus.cpu_wr_data  = 8'(wdata);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int ack_i, we_i, addr_i, wd_i, rdy_i, lvl_i, dv_i, dd_i;

    task automatic grab();
        ack_i  = int'(bus.disp_ack);
        we_i   = int'(bus.ram_we);
        addr_i = int'(bus.ram_addr);
        wd_i   = int'(bus.ram_wdata);
        rdy_i  = int'(bus.cpu_wr_ready);
        lvl_i  = int'(bus.fifo_level);
        dv_i   = int'(bus.disp_valid);
        dd_i   = int'(bus.disp_data);
    endtask

    vec_t vt [NVEC];

    initial begin
        int wa[$];
        int wdq[$];
        int nw;

        //          dreq daddr  push waddr  wdata  ack we ca raddr   wd    rdy lvl dv dd
        vt[0]  = '{0, 0,      0, 0,      0,     0, 0, 0, 0,      0,    1, 0, 0, 0};
        vt[1]  = '{0, 0,      1, 'h0010, 'hA5,  0, 0, 0, 0,      0,    1, 0, 0, 0};
        vt[2]  = '{0, 0,      0, 0,      0,     0, 1, 1, 'h0010, 'hA5, 1, 1, 0, 0};
        vt[3]  = '{1, 'h0010, 0, 0,      0,     1, 0, 1, 'h0010, 0,    1, 0, 0, 0};
        vt[4]  = '{1, 'h0010, 1, 'h0030, 'h5A,  1, 0, 1, 'h0010, 0,    1, 0, 0, 0};
        vt[5]  = '{0, 0,      0, 0,      0,     0, 1, 1, 'h0030, 'h5A, 1, 1, 1, 'hA5};
        vt[6]  = '{0, 0,      0, 0,      0,     0, 0, 1, 'h0030, 0,    1, 0, 1, 'hA5};
        vt[7]  = '{0, 0,      0, 0,      0,     0, 0, 1, 'h0030, 0,    1, 0, 0, 0};
        vt[8]  = '{1, 'h0030, 0, 0,      0,     1, 0, 1, 'h0030, 0,    1, 0, 0, 0};
        vt[9]  = '{0, 0,      0, 0,      0,     0, 0, 1, 'h0030, 0,    1, 0, 0, 0};
        vt[10] = '{0, 0,      0, 0,      0,     0, 0, 1, 'h0030, 0,    1, 0, 1, 'h5A};
        vt[11] = '{0, 0,      0, 0,      0,     0, 0, 1, 'h0030, 0,    1, 0, 0, 0};
        vt[12] = '{1, 'h0010, 1, 'h0040, 'h3C,  1, 0, 1, 'h0010, 0,    1, 0, 0, 0};
        vt[13] = '{1, 'h0010, 0, 0,      0,     1, 0, 1, 'h0010, 0,    1, 1, 0, 0};
        vt[14] = '{0, 0,      0, 0,      0,     0, 1, 1, 'h0040, 'h3C, 1, 1, 1, 'hA5};
        vt[15] = '{0, 0,      1, 'h0010, 'hC3,  0, 0, 1, 'h0040, 0,    1, 0, 1, 'hA5};
        vt[16] = '{1, 'h0010, 0, 0,      0,     1, 0, 1, 'h0010, 0,    1, 1, 0, 0};
        vt[17] = '{0, 0,      0, 0,      0,     0, 1, 1, 'h0010, 'hC3, 1, 1, 0, 0};
        vt[18] = '{0, 0,      0, 0,      0,     0, 0, 1, 'h0010, 0,    1, 0, 1, 'hA5};
        vt[19] = '{1, 'h0010, 0, 0,      0,     1, 0, 1, 'h0010, 0,    1, 0, 0, 0};
        vt[20] = '{0, 0,      0, 0,      0,     0, 0, 1, 'h0010, 0,    1, 0, 0, 0};
        vt[21] = '{0, 0,      0, 0,      0,     0, 0, 1, 'h0010, 0,    1, 0, 1, 'hC3};

        // Reset then idle for 10 cycles.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 0, 0, 0);
            @(negedge clk);
            grab();
            chk($sformatf("idle%0d.rdy", c), rdy_i, 1);
            chk($sformatf("idle%0d.lvl", c), lvl_i, 0);
            chk($sformatf("idle%0d.dv", c), dv_i, 0);
            chk($sformatf("idle%0d.we", c), we_i, 0);
            tick();
        end

        // Vector table.
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            drive(vt[i].dreq, vt[i].daddr, vt[i].push, vt[i].waddr, vt[i].wdata);
            @(negedge clk);
            grab();
            chk($sformatf("v%0d.ack", i), ack_i, vt[i].ack);
            chk($sformatf("v%0d.we", i), we_i, vt[i].we);
            chk($sformatf("v%0d.rdy", i), rdy_i, vt[i].rdy);
            chk($sformatf("v%0d.lvl", i), lvl_i, vt[i].lvl);
            chk($sformatf("v%0d.dv", i), dv_i, vt[i].dv);
            if (vt[i].ca != 0) chk($sformatf("v%0d.addr", i), addr_i, vt[i].raddr);
            if (vt[i].we != 0) chk($sformatf("v%0d.wdata", i), wd_i, vt[i].wd);
            if (vt[i].dv != 0) chk($sformatf("v%0d.ddata", i), dd_i, vt[i].dd);
            tick();
        end

        // Five pushes while display holds the RAM: the fifth is dropped.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 'h100, 1, 'h200 + i, 'h10 + i);
            @(negedge clk);
            grab();
            chk($sformatf("full%0d.we", i), we_i, 0);
            chk($sformatf("full%0d.lvl", i), lvl_i, i < 4 ? i : 4);
            chk($sformatf("full%0d.rdy", i), rdy_i, i < 4 ? 1 : 0);
            tick();
        end
        drive(1, 'h100, 0, 0, 0);
        @(negedge clk);
        grab();
        chk("full.lvl_after", lvl_i, 4);
        chk("full.we_after", we_i, 0);
        tick();
        wa.delete();
        wdq.delete();
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 0, 0);
            @(negedge clk);
            if (bus.ram_we) begin
                wa.push_back(int'(bus.ram_addr));
                wdq.push_back(int'(bus.ram_wdata));
            end
            tick();
        end
        nw = wa.size();
        chk("full.nwrites", nw, 4);
        for (int k = 0; k < 4 && k < nw; k++) begin
            chk($sformatf("full.w%0d.addr", k), wa[k], 'h200 + k);
            chk($sformatf("full.w%0d.data", k), wdq[k], 'h10 + k);
        end

        // Continuous display traffic with one queued write.
        do_reset();
        nw = 0;
        drive(1, 'h300, 1, 'h400, 'h77);
        @(negedge clk);
        grab();
        chk("starve.p.ack", ack_i, 1);
        chk("starve.p.we", we_i, 0);
        tick();
        for (int j = 1; j <= 12; j++) begin
            int exp_we;
            drive(1, 'h300, 0, 0, 0);
            @(negedge clk);
            grab();
`ifdef VRAM_ARB_STARVE_GUARD_EN
            exp_we = (j == STARVE_LIMIT + 1) ? 1 : 0;
`else
            exp_we = 0;
`endif
            chk($sformatf("starve%0d.we", j), we_i, exp_we);
            chk($sformatf("starve%0d.ack", j), ack_i, 1 - exp_we);
            if (exp_we != 0) begin
                chk($sformatf("starve%0d.addr", j), addr_i, 'h400);
                chk($sformatf("starve%0d.wdata", j), wd_i, 'h77);
            end
            if (we_i != 0) nw++;
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 0, 0);
            @(negedge clk);
            if (bus.ram_we) nw++;
            tick();
        end
        chk("starve.total_writes", nw, 1);

        // Push and pop in the same cycle at level 2.
        do_reset();
        drive(1, 'h100, 1, 'h500, 'h01);
        @(negedge clk); grab();
        chk("pp0.lvl", lvl_i, 0);
        tick();
        drive(1, 'h100, 1, 'h501, 'h02);
        @(negedge clk); grab();
        chk("pp1.lvl", lvl_i, 1);
        chk("pp1.we", we_i, 0);
        tick();
        drive(0, 0, 1, 'h502, 'h03);
        @(negedge clk); grab();
        chk("pp2.lvl", lvl_i, 2);
        chk("pp2.we", we_i, 1);
        chk("pp2.addr", addr_i, 'h500);
        chk("pp2.wdata", wd_i, 'h01);
        tick();
        drive(0, 0, 0, 0, 0);
        @(negedge clk); grab();
        chk("pp3.lvl", lvl_i, 2);
        chk("pp3.we", we_i, 1);
        chk("pp3.addr", addr_i, 'h501);
        chk("pp3.wdata", wd_i, 'h02);
        tick();
        @(negedge clk); grab();
        chk("pp4.lvl", lvl_i, 1);
        chk("pp4.addr", addr_i, 'h502);
        chk("pp4.wdata", wd_i, 'h03);
        tick();
        @(negedge clk); grab();
        chk("pp5.lvl", lvl_i, 0);
        chk("pp5.we", we_i, 0);
        tick();

        // Reset with a read in flight and three writes queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h700, 1, 'h600 + i, 'hE0 + i);
            @(negedge clk); grab();
            if (i == 2) begin
                chk("rst.pre.ack", ack_i, 1);
                chk("rst.pre.lvl", lvl_i, 2);
            end
            tick();
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        @(negedge clk); grab();
        chk("rst.in.lvl", lvl_i, 3);
        chk("rst.in.we", we_i, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); grab();
            chk($sformatf("rst.post%0d.dv", c), dv_i, 0);
            chk($sformatf("rst.post%0d.we", c), we_i, 0);
            chk($sformatf("rst.post%0d.lvl", c), lvl_i, 0);
            chk($sformatf("rst.post%0d.rdy", c), rdy_i, 1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
